// File: rtl/vid_axis_pkg.sv
// Shared definitions for the video-to-AXI4-Stream transmitter.
//   ST_*      : FSM state codes (2 bits)
//   W         : FIFO word width, layout {tuser, tlast, rgb[23:0]}
//   dbg_t     : debug tap (FSM state, pending tuser, FIFO full, registered hs)
//   pack_word : builds one FIFO word
//   sat_inc   : 16-bit increment that sticks at 16'hFFFF
package vid_axis_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam int W = 26;

  typedef struct packed {
    logic [1:0] state;
    logic       tuser_pend;
    logic       fifo_full;
    logic       hs;
  } dbg_t;

  function automatic logic [W-1:0] pack_word(input logic tuser, input logic tlast,
                                             input logic [23:0] rgb);
    return {tuser, tlast, rgb};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vid_axis_if.sv
// AXI4-Stream video bus: tdata {8'h00, rgb}, tuser = start of frame, tlast = end of line.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready are both 1. Once the
// master raises tvalid it keeps tvalid, tdata, tuser and tlast stable until that transfer; tvalid
// never depends on tready, while tready may depend on tvalid.
interface vid_axis_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/vid_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n       : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, wr_data   : write request; taken when not full, or when full with a read the same cycle
//   rd_en            : read request; pops the head when not empty
//   rd_data          : head word, valid whenever empty == 0
//   count/full/empty : occupancy ($clog2(DEPTH)+1 bits)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module vid_sync_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // At full a write is only legal when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_axis_tx.sv
// Parallel RGB video (vs/hs/de/rgb, one pixel per clk) to AXI4-Stream video master.
//   clk, rst_n           : clock, synchronous active-low reset
//   en                   : capture enable, acted on at frame start
//   vid_vs/hs/de/rgb     : video timing input; vs polarity VS_POL, hs only feeds the debug tap
//   axis (master)        : tdata {8'h00,rgb}, tvalid, tready, tuser (SOF), tlast (EOL)
//   ovf                  : sticky overflow, cleared by reset or an enabled frame start
//   err_line, err_frame  : 1-clk pulses for wrong line width / wrong line count
//   frame_cnt            : frames started in ACTIVE (wrapping)
//   dbg                  : FSM state and internal flags
// A pixel with de=1 sits one cycle in a hold register; the following de value decides whether it
// closes the line (tlast). Pushes happen only in ACTIVE; a push into a full FIFO with no pop in the
// same cycle loses the pixel and parks the FSM in DROP until the next SOF.
module vid_axis_tx
  import vid_axis_pkg::*;
#(
  parameter int   H_ACTIVE   = 480,
  parameter int   V_ACTIVE   = 272,
  parameter int   FIFO_DEPTH = 1024,
  parameter logic VS_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        vid_vs,
  input  logic        vid_hs,
  input  logic        vid_de,
  input  logic [23:0] vid_rgb,
  vid_axis_if.master  axis,
  output logic        ovf,
  output logic        err_line,
  output logic        err_frame,
  output logic [15:0] frame_cnt,
  output dbg_t        dbg
);
  localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] H16 = 16'(H_ACTIVE);
  localparam logic [15:0] V16 = 16'(V_ACTIVE);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic         vs_q;
  logic         hs_q;
  logic         sof;
  logic         hold_v;
  logic [23:0]  hold_rgb;
  logic         tuser_pend;
  logic [15:0]  x_cnt;
  logic [15:0]  y_cnt;

  logic         push_req;
  logic         push_ok;
  logic         push_tlast;
  logic         pop;
  logic         overflow;
  logic         start_frame;

  logic [W-1:0] fifo_din;
  logic [W-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;

  // SOF: vs is at its active level now and was not last cycle.
  assign sof         = (vid_vs == VS_POL) && (vs_q != VS_POL);
  assign push_req    = hold_v && (state == ST_ACTIVE);
  assign push_tlast  = !vid_de;
  assign pop         = axis.tvalid && axis.tready;
  assign overflow    = push_req && (fifo_count == CW'(FIFO_DEPTH)) && !pop;
  assign push_ok     = push_req && !overflow;
  // Every SOF seen outside IDLE with en=1 lands in ACTIVE with a new frame.
  assign start_frame = sof && en && (state != ST_IDLE);
  assign fifo_din    = pack_word(tuser_pend, push_tlast, hold_rgb);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (en) state_nxt = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!en)     state_nxt = ST_IDLE;
        else if (sof) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (sof)           state_nxt = en ? ST_ACTIVE : ST_IDLE;
        else if (overflow) state_nxt = ST_DROP;
      end
      ST_DROP:     if (sof) state_nxt = en ? ST_ACTIVE : ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      // Start at the active level so a vs already asserted out of reset is not taken as SOF.
      vs_q       <= VS_POL;
      hs_q       <= 1'b0;
      hold_v     <= 1'b0;
      hold_rgb   <= '0;
      tuser_pend <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      state    <= state_nxt;
      vs_q     <= vid_vs;
      hs_q     <= vid_hs;
      hold_v   <= vid_de;
      hold_rgb <= vid_rgb;

      // A held pixel pushed on the SOF cycle still uses the old frame's flag.
      if (start_frame)  tuser_pend <= 1'b1;
      else if (push_ok) tuser_pend <= 1'b0;

      if (push_ok) x_cnt <= push_tlast ? 16'd0 : sat_inc(x_cnt);
      else if (sof) x_cnt <= 16'd0;
      err_line <= push_ok && push_tlast && (sat_inc(x_cnt) != H16);

      if (sof)                        y_cnt <= 16'd0;
      else if (push_ok && push_tlast) y_cnt <= sat_inc(y_cnt);
      err_frame <= sof && (state == ST_ACTIVE) && (y_cnt != V16);

      if (start_frame) frame_cnt <= frame_cnt + 16'd1;

      if (overflow)         ovf <= 1'b1;
      else if (start_frame) ovf <= 1'b0;
    end
  end

  vid_sync_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_ok),
    .wr_data (fifo_din),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Outputs read 0 while empty so nothing stale is presented after reset.
  assign axis.tvalid = !fifo_empty;
  assign axis.tdata  = fifo_empty ? 32'd0 : {8'h00, fifo_dout[23:0]};
  assign axis.tuser  = !fifo_empty && fifo_dout[25];
  assign axis.tlast  = !fifo_empty && fifo_dout[24];

  assign dbg.state      = state;
  assign dbg.tuser_pend = tuser_pend;
  assign dbg.fifo_full  = fifo_full;
  assign dbg.hs         = hs_q;

endmodule
